mkio_bc_scheduler: RTL and testbench

MKIO_BC_SCHEDULER -- requirements
Module: mkio_bc_scheduler

---
 rtl/mkio_bc_scheduler.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mkio_bc_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mkio_bc_scheduler.sv
// mkio_bc_scheduler
//   Bus-controller frame scheduler for a MIL-STD-1553-style (MKIO) link. It walks
//   a small command table once per frame. Each enabled entry is sent to the
//   encoder as a command word, and then the scheduler waits for the RT status
//   reply. For RT-to-BC transfers it then collects the data words and forwards
//   them on a simple write port. Entries that fail set a bit in err_flags.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   frame_start                   one-clock pulse, starts a frame when idle
//   cmd_we/cmd_wr_addr/cmd_wr_data  command-table write port
//   msg_en[NUM_MSG]               per-entry enable mask, latched at frame start
//   tx_data/tx_cd/tx_ready/tx_busy  encoder handshake
//   rx_data/rx_valid/rx_cd/p_error  decoder word strobe and flags
//   data_we/data_msg/data_addr/data_out  received-data write port
//   busy, frame_done, err_flags   frame status
//
// Build option
//   MKIO_BC_RETRY_EN : when defined, a failed entry is re-sent once before its
//                      error flag is set.
//
// State table
//   state        | meaning
//   IDLE         | waiting for frame_start
//   LOAD_CMD     | fetch entry[index], skip if disabled or broadcast (RT 31)
//   WAIT_TX      | hold until the encoder is free
//   SEND_CMD     | one-clock tx_ready, arm the response timer
//   WAIT_STATUS  | wait for the addressed RT's status word
//   RECV_DATA    | collect word-count data words
//   NEXT_MSG     | advance index or finish
//   DONE         | one-clock frame_done, then back to IDLE

module mkio_bc_scheduler #(
  parameter int         NUM_MSG      = 8,
  parameter logic [7:0] RESP_TIMEOUT = 8'd200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               cmd_we,
  input  logic [2:0]         cmd_wr_addr,
  input  logic [15:0]        cmd_wr_data,
  input  logic [NUM_MSG-1:0] msg_en,
  output logic [15:0]        tx_data,
  output logic               tx_cd,
  output logic               tx_ready,
  input  logic               tx_busy,
  input  logic [15:0]        rx_data,
  input  logic               rx_valid,
  input  logic               rx_cd,
  input  logic               p_error,
  output logic               data_we,
  output logic [2:0]         data_msg,
  output logic [4:0]         data_addr,
  output logic [15:0]        data_out,
  output logic               busy,
  output logic               frame_done,
  output logic [NUM_MSG-1:0] err_flags
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CMD,
    S_WAIT_TX,
    S_SEND_CMD,
    S_WAIT_STATUS,
    S_RECV_DATA,
    S_NEXT_MSG,
    S_DONE
  } state_t;

  localparam logic [2:0] LP_LAST = 3'(NUM_MSG - 1);
  localparam logic [3:0] LP_NUM  = 4'(NUM_MSG);

  state_t             r_state;
  state_t             w_next_state;

  logic [15:0]        r_table [NUM_MSG];
  logic [NUM_MSG-1:0] r_en_mask;
  logic [NUM_MSG-1:0] r_err;
  logic [2:0]         r_index;
  logic [15:0]        r_cmd;
  logic [4:0]         r_word;
  logic [7:0]         r_tmo;
  logic               r_seen_busy;
  logic               r_tmo_arm;
  logic               r_data_we;
  logic [2:0]         r_data_msg;
  logic [4:0]         r_data_addr;
  logic [15:0]        r_data_out;

  logic [15:0]        w_entry;
  logic               w_skip;
  logic               w_timeout;
  logic               w_rt_match;
  logic               w_status_ok;
  logic               w_status_fail;
  logic               w_word_ok;
  logic               w_data_fail;
  logic               w_last_word;
  logic               w_fail;
  logic               w_retry_now;
  logic               w_err_set;

  assign w_entry    = r_table[r_index];
  // RT address 31 is the broadcast address; broadcasts get no status reply.
  assign w_skip     = !r_en_mask[r_index] || (w_entry[15:11] == 5'd31);
  assign w_timeout  = (r_tmo == RESP_TIMEOUT);
  assign w_rt_match = (rx_data[15:11] == r_cmd[15:11]);

  // A valid word wins over a timeout landing on the same clock.
  assign w_status_ok   = rx_valid && !rx_cd && !p_error && w_rt_match;
  assign w_status_fail = !w_status_ok && (p_error || (rx_valid && !rx_cd) || w_timeout);
  assign w_word_ok     = rx_valid && rx_cd && !p_error;
  assign w_data_fail   = !w_word_ok && (p_error || (rx_valid && !rx_cd) || w_timeout);

  // Word count 0 encodes 32; the 5-bit wrap of (0 - 1) gives 31 for free.
  assign w_last_word = (r_word == (r_cmd[4:0] - 5'd1));

  assign w_fail = ((r_state == S_WAIT_STATUS) && w_status_fail) ||
                  ((r_state == S_RECV_DATA) && w_data_fail);

`ifdef MKIO_BC_RETRY_EN
  logic r_retry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retry <= 1'b0;
    end else if (w_retry_now) begin
      r_retry <= 1'b1;
    end else if ((r_state == S_NEXT_MSG) || (r_state == S_IDLE)) begin
      r_retry <= 1'b0;
    end
  end

  assign w_retry_now = w_fail && !r_retry;
`else
  assign w_retry_now = 1'b0;
`endif

  assign w_err_set = w_fail && !w_retry_now;

  // Command table; writes are accepted in any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MSG; i++) begin
        r_table[i] <= 16'd0;
      end
    end else if (cmd_we && ({1'b0, cmd_wr_addr} < LP_NUM)) begin
      r_table[cmd_wr_addr] <= cmd_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:        if (frame_start) w_next_state = S_LOAD_CMD;
      S_LOAD_CMD:    w_next_state = w_skip ? S_NEXT_MSG : S_WAIT_TX;
      S_WAIT_TX:     if (!tx_busy) w_next_state = S_SEND_CMD;
      S_SEND_CMD:    w_next_state = S_WAIT_STATUS;
      S_WAIT_STATUS: begin
        if (w_status_ok) begin
          w_next_state = r_cmd[10] ? S_RECV_DATA : S_NEXT_MSG;
        end else if (w_fail) begin
          w_next_state = w_retry_now ? S_LOAD_CMD : S_NEXT_MSG;
        end
      end
      S_RECV_DATA: begin
        if (w_word_ok) begin
          if (w_last_word) w_next_state = S_NEXT_MSG;
        end else if (w_fail) begin
          w_next_state = w_retry_now ? S_LOAD_CMD : S_NEXT_MSG;
        end
      end
      S_NEXT_MSG:    w_next_state = (r_index == LP_LAST) ? S_DONE : S_LOAD_CMD;
      S_DONE:        w_next_state = S_IDLE;
      default:       w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready   = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE:     busy       = 1'b0;
      S_SEND_CMD: tx_ready   = 1'b1;
      S_DONE:     frame_done = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_mask   <= '0;
      r_err       <= '0;
      r_index     <= 3'd0;
      r_cmd       <= 16'd0;
      r_word      <= 5'd0;
      r_tmo       <= 8'd0;
      r_seen_busy <= 1'b0;
      r_tmo_arm   <= 1'b0;
      r_data_we   <= 1'b0;
      r_data_msg  <= 3'd0;
      r_data_addr <= 5'd0;
      r_data_out  <= 16'd0;
    end else begin
      r_data_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_en_mask <= msg_en;
            r_err     <= '0;
            r_index   <= 3'd0;
          end
        end
        S_LOAD_CMD: begin
          r_word <= 5'd0;
          if (!w_skip) r_cmd <= w_entry;
        end
        S_SEND_CMD: begin
          r_tmo       <= 8'd0;
          r_seen_busy <= 1'b0;
          r_tmo_arm   <= 1'b0;
        end
        S_WAIT_STATUS: begin
          // The reply window opens only once the encoder has finished
          // shifting the command out (busy seen high, then low).
          if (tx_busy) r_seen_busy <= 1'b1;
          if (r_seen_busy && !tx_busy) r_tmo_arm <= 1'b1;
          if (w_status_ok) begin
            r_tmo <= 8'd0;
          end else if (r_tmo_arm && !w_timeout) begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        S_RECV_DATA: begin
          if (w_word_ok) begin
            r_data_we   <= 1'b1;
            r_data_out  <= rx_data;
            r_data_addr <= r_word;
            r_data_msg  <= r_index;
            r_word      <= r_word + 5'd1;
            r_tmo       <= 8'd0;
          end else if (!w_timeout) begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        S_NEXT_MSG: begin
          if (r_index != LP_LAST) r_index <= r_index + 3'd1;
        end
        default: ;
      endcase
      if (w_err_set) r_err[r_index] <= 1'b1;
    end
  end

  assign tx_data   = r_cmd;
  assign tx_cd     = 1'b0;
  assign data_we   = r_data_we;
  assign data_msg  = r_data_msg;
  assign data_addr = r_data_addr;
  assign data_out  = r_data_out;
  assign err_flags = r_err;

endmodule

// File: tb/tb_mkio_bc_scheduler.sv
module tb_mkio_bc_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        cmd_we = 1'b0;
  logic [2:0]  cmd_wr_addr = 3'd0;
  logic [15:0] cmd_wr_data = 16'd0;
  logic [7:0]  msg_en = 8'd0;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_ready;
  logic        tx_busy = 1'b0;
  logic [15:0] rx_data = 16'd0;
  logic        rx_valid = 1'b0;
  logic        rx_cd = 1'b0;
  logic        p_error = 1'b0;
  logic        data_we;
  logic [2:0]  data_msg;
  logic [4:0]  data_addr;
  logic [15:0] data_out;
  logic        busy;
  logic        frame_done;
  logic [7:0]  err_flags;

  mkio_bc_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .cmd_we      (cmd_we),
    .cmd_wr_addr (cmd_wr_addr),
    .cmd_wr_data (cmd_wr_data),
    .msg_en      (msg_en),
    .tx_data     (tx_data),
    .tx_cd       (tx_cd),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_cd       (rx_cd),
    .p_error     (p_error),
    .data_we     (data_we),
    .data_msg    (data_msg),
    .data_addr   (data_addr),
    .data_out    (data_out),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_flags   (err_flags)
  );

  always #5 clk = ~clk;

`ifdef MKIO_BC_RETRY_EN
  localparam int TX_PER_FAIL = 2;
`else
  localparam int TX_PER_FAIL = 1;
`endif

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Encoder model: each tx_ready keeps the encoder busy for four clocks.
  int          cmd_cnt = 0;
  logic [15:0] cmd_last = 16'd0;
  logic        cmd_cd_last = 1'b0;
  int          bcnt = 0;
  always @(negedge clk) begin
    if (tx_ready) begin
      cmd_cnt++;
      cmd_last    = tx_data;
      cmd_cd_last = tx_cd;
      tx_busy     = 1'b1;
      bcnt        = 4;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) tx_busy = 1'b0;
    end
  end

  // Output monitor.
  int          dw_cnt = 0;
  int          fd_cnt = 0;
  logic [15:0] dw_data [64];
  logic [4:0]  dw_addr [64];
  logic [2:0]  dw_msg  [64];
  always @(negedge clk) begin
    if (data_we) begin
      dw_data[dw_cnt[5:0]] = data_out;
      dw_addr[dw_cnt[5:0]] = data_addr;
      dw_msg[dw_cnt[5:0]]  = data_msg;
      dw_cnt++;
    end
    if (frame_done) fd_cnt++;
  end

  task automatic wr_entry(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    cmd_we = 1'b1; cmd_wr_addr = a; cmd_wr_data = d;
    @(negedge clk);
    cmd_we = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] m);
    @(negedge clk);
    msg_en = m; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_cmd(input int base, input string tag);
    for (int i = 0; i < 100 && cmd_cnt <= base; i++) @(negedge clk);
    chk(tag, cmd_cnt - base, 1);
    for (int i = 0; i < 20 && tx_busy; i++) @(negedge clk);
  endtask

  task automatic wait_fd(input int base, input int limit, input string tag, output int cycles);
    cycles = 0;
    while (fd_cnt <= base && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    chk(tag, fd_cnt - base, 1);
  endtask

  task automatic send_word(input logic [15:0] d, input logic cd, input logic pe);
    @(negedge clk);
    rx_data = d; rx_cd = cd; p_error = pe; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; p_error = 1'b0;
  endtask

  initial begin
    int cb, db, fb, cyc;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_txrdy", tx_ready, 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_dwe", data_we, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // RT1 transmit, two data words
    wr_entry(3'd0, 16'h0C22);
    cb = cmd_cnt; db = dw_cnt; fb = fd_cnt;
    start_frame(8'h01);
    chk("t1_busy", busy, 1);
    wait_cmd(cb, "t1_cmd");
    chk("t1_txdata", cmd_last, 16'h0C22);
    chk("t1_txcd", cmd_cd_last, 0);
    send_word(16'h0800, 1'b0, 1'b0);
    send_word(16'hAAAA, 1'b1, 1'b0);
    send_word(16'h5555, 1'b1, 1'b0);
    wait_fd(fb, 100, "t1_fd", cyc);
    chk("t1_dwcnt", dw_cnt - db, 2);
    chk("t1_a0", dw_addr[db[5:0]], 0);
    chk("t1_d0", dw_data[db[5:0]], 16'hAAAA);
    chk("t1_a1", dw_addr[(db + 1) % 64], 1);
    chk("t1_d1", dw_data[(db + 1) % 64], 16'h5555);
    chk("t1_msg", dw_msg[db[5:0]], 0);
    chk("t1_err", err_flags, 0);
    @(negedge clk);
    chk("t1_idle", busy, 0);

    // Entry 1 transfer: data_msg carries the index
    wr_entry(3'd1, 16'h2C01);
    cb = cmd_cnt; db = dw_cnt; fb = fd_cnt;
    start_frame(8'h02);
    wait_cmd(cb, "t1b_cmd");
    chk("t1b_txdata", cmd_last, 16'h2C01);
    send_word(16'h2800, 1'b0, 1'b0);
    send_word(16'h1234, 1'b1, 1'b0);
    wait_fd(fb, 100, "t1b_fd", cyc);
    chk("t1b_dwcnt", dw_cnt - db, 1);
    chk("t1b_msg", dw_msg[db[5:0]], 1);
    chk("t1b_d0", dw_data[db[5:0]], 16'h1234);
    chk("t1b_err", err_flags, 0);

    // Word count 0 means 32 words
    wr_entry(3'd0, 16'h2420);
    cb = cmd_cnt; db = dw_cnt; fb = fd_cnt;
    start_frame(8'h01);
    wait_cmd(cb, "wc32_cmd");
    send_word(16'h2000, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) send_word(16'h0100 + 16'(i), 1'b1, 1'b0);
    wait_fd(fb, 100, "wc32_fd", cyc);
    chk("wc32_dwcnt", dw_cnt - db, 32);
    chk("wc32_alast", dw_addr[(db + 31) % 64], 31);
    chk("wc32_dlast", dw_data[(db + 31) % 64], 16'h011F);
    chk("wc32_err", err_flags, 0);

    // RT2 receive with no status reply -> timeout
    wr_entry(3'd0, 16'h1021);
    cb = cmd_cnt; db = dw_cnt; fb = fd_cnt;
    start_frame(8'h01);
    wait_fd(fb, 1000, "t2_fd", cyc);
    chk("t2_err", err_flags, 8'h01);
    chk("t2_cmds", cmd_cnt - cb, TX_PER_FAIL);
    chk("t2_dwcnt", dw_cnt - db, 0);
    chk("t2_tmin", (cyc >= 200 * TX_PER_FAIL), 1);
    chk("t2_tmax", (cyc <= 260 * TX_PER_FAIL), 1);

    // Status from the wrong RT
    wr_entry(3'd0, 16'h0C22);
    cb = cmd_cnt; db = dw_cnt; fb = fd_cnt;
    start_frame(8'h01);
    wait_cmd(cb, "t3_cmd");
    send_word(16'h1800, 1'b0, 1'b0);
    wait_fd(fb, 1000, "t3_fd", cyc);
    chk("t3_err", err_flags, 8'h01);
    chk("t3_dwcnt", dw_cnt - db, 0);

    // Broadcast / disabled entries only
    wr_entry(3'd0, 16'hF800);
    wr_entry(3'd2, 16'hFC22);
    cb = cmd_cnt; fb = fd_cnt;
    start_frame(8'h05);
    wait_fd(fb, 30, "t4_fd", cyc);
    chk("t4_cmds", cmd_cnt - cb, 0);
    chk("t4_time", (cyc <= 20), 1);
    chk("t4_err", err_flags, 0);

    // Reset during RECV_DATA
    wr_entry(3'd0, 16'h0C22);
    cb = cmd_cnt; db = dw_cnt; fb = fd_cnt;
    start_frame(8'h01);
    wait_cmd(cb, "t5_cmd");
    send_word(16'h0800, 1'b0, 1'b0);
    send_word(16'hAAAA, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_dw1", dw_cnt - db, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_txdata", tx_data, 0);
    chk("t5_err", err_flags, 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_nofd", fd_cnt - fb, 0);
    wr_entry(3'd0, 16'h0C22);
    cb = cmd_cnt; db = dw_cnt; fb = fd_cnt;
    start_frame(8'h01);
    wait_cmd(cb, "t5b_cmd");
    send_word(16'h0800, 1'b0, 1'b0);
    send_word(16'hBEEF, 1'b1, 1'b0);
    send_word(16'hCAFE, 1'b1, 1'b0);
    wait_fd(fb, 100, "t5b_fd", cyc);
    chk("t5b_dwcnt", dw_cnt - db, 2);
    chk("t5b_d1", dw_data[(db + 1) % 64], 16'hCAFE);
    chk("t5b_err", err_flags, 0);

    // frame_start while busy, table rewrite mid-message
    cb = cmd_cnt; db = dw_cnt; fb = fd_cnt;
    start_frame(8'h01);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_cmd(cb, "t6_cmd");
    wr_entry(3'd0, 16'h1234);
    chk("t6_txhold", tx_data, 16'h0C22);
    send_word(16'h0800, 1'b0, 1'b0);
    send_word(16'h1111, 1'b1, 1'b0);
    send_word(16'h2222, 1'b1, 1'b0);
    wait_fd(fb, 100, "t6_fd", cyc);
    repeat (40) @(negedge clk);
    chk("t6_fdcnt", fd_cnt - fb, 1);
    chk("t6_cmds", cmd_cnt - cb, 1);
    chk("t6_dwcnt", dw_cnt - db, 2);

    // rx_valid while idle is ignored
    db = dw_cnt;
    send_word(16'h0800, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("t7_dw", dw_cnt - db, 0);
    chk("t7_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
